// File: rtl/servant_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : servant_wb_arbiter
// Brief    : Round-robin Wishbone arbiter between an instruction-fetch master
//            and a data master, with a slave-ack watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module servant_wb_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_wb_ibus_adr,
    input  logic        i_wb_ibus_cyc,
    output logic        o_wb_ibus_ack,
    input  logic [31:0] i_wb_dbus_adr,
    input  logic [31:0] i_wb_dbus_dat,
    input  logic [3:0]  i_wb_dbus_sel,
    input  logic        i_wb_dbus_we,
    input  logic        i_wb_dbus_cyc,
    output logic        o_wb_dbus_ack,
    output logic [31:0] o_wb_rdt,
    output logic [31:0] o_wb_cpu_adr,
    output logic [31:0] o_wb_cpu_dat,
    output logic [3:0]  o_wb_cpu_sel,
    output logic        o_wb_cpu_we,
    output logic        o_wb_cpu_cyc,
    input  logic [31:0] i_wb_cpu_rdt,
    input  logic        i_wb_cpu_ack,
    output logic        o_timeout_err
);

    localparam int              c_CW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [c_CW-1:0] c_LIMIT = c_CW'(TIMEOUT);
    localparam logic [c_CW-1:0] c_ONE   = c_CW'(1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_GNT_I = 2'd1;
    localparam logic [1:0] c_GNT_D = 2'd2;

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic            r_last_d;
    logic [c_CW-1:0] r_cnt;

    logic w_gnt_i;
    logic w_gnt_d;
    logic w_req;
    logic w_fwd_ack;
    logic w_expire;

    assign w_gnt_i   = (r_state == c_GNT_I);
    assign w_gnt_d   = (r_state == c_GNT_D);
    assign w_req     = (w_gnt_i & i_wb_ibus_cyc) | (w_gnt_d & i_wb_dbus_cyc);
    assign w_fwd_ack = w_req & i_wb_cpu_ack;
    // A real slave ack in the expiry cycle takes precedence over the watchdog.
    assign w_expire  = (TIMEOUT != 0) && w_req && !i_wb_cpu_ack && (r_cnt == c_LIMIT);

    assign o_wb_cpu_cyc  = w_req & ~w_expire;
    assign o_wb_ibus_ack = w_gnt_i & (w_fwd_ack | w_expire);
    assign o_wb_dbus_ack = w_gnt_d & (w_fwd_ack | w_expire);
    assign o_timeout_err = w_expire;
    assign o_wb_rdt      = w_expire ? 32'h0 : i_wb_cpu_rdt;

    assign o_wb_cpu_adr  = w_gnt_i ? i_wb_ibus_adr : i_wb_dbus_adr;
    assign o_wb_cpu_dat  = w_gnt_i ? 32'h0 : i_wb_dbus_dat;
    assign o_wb_cpu_sel  = w_gnt_i ? 4'hF : i_wb_dbus_sel;
    assign o_wb_cpu_we   = ~w_gnt_i & i_wb_dbus_we;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (i_wb_ibus_cyc && i_wb_dbus_cyc)
                    w_state_nxt = r_last_d ? c_GNT_I : c_GNT_D;
                else if (i_wb_ibus_cyc)
                    w_state_nxt = c_GNT_I;
                else if (i_wb_dbus_cyc)
                    w_state_nxt = c_GNT_D;
            end
            default: begin
                // Any completion, abandonment or watchdog expiry ends the grant.
                if (!w_req || w_fwd_ack || w_expire)
                    w_state_nxt = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= c_IDLE;
            r_last_d <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == c_IDLE && w_state_nxt != c_IDLE)
                r_last_d <= (w_state_nxt == c_GNT_D);
            if (r_state == c_IDLE)
                r_cnt <= '0;
            else if (!i_wb_cpu_ack && r_cnt != c_LIMIT)
                r_cnt <= r_cnt + c_ONE;
        end
    end

endmodule
`default_nettype wire
